waves_nios_led_sequencer: RTL

Avalon-MM slave controller that drives the board LED bank from a small pattern table without CPU involvement.
Nios software loads up to DEPTH patterns, a step period and a sequence length, then starts free-running or one-shot playback.
When idle, the LEDs show a software-written manual value.
It sits between the Nios data master and the LED pins, in place of a bare output PIO.

---
 rtl/waves_nios_led_sequencer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/waves_nios_led_sequencer.sv
// Avalon-MM LED pattern sequencer: plays a small pattern table on the LED bank
// with a programmable step period, free-running or one-shot.
module waves_nios_led_sequencer #(
    parameter int DATA_WIDTH     = 8,
    parameter int DEPTH          = 8,
    parameter int PRESCALE_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [3:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  irq
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] DEPTH4 = 4'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [2:0]                ctrl_q, ctrl_d;
    logic                      done_q, done_d;
    logic [PRESCALE_WIDTH-1:0] period_q, period_d;
    logic [IW-1:0]             length_q, length_d;
    logic [DATA_WIDTH-1:0]     manual_q, manual_d;
    logic [DATA_WIDTH-1:0]     pattern_q [DEPTH];
    logic [DATA_WIDTH-1:0]     pattern_d [DEPTH];
    logic [IW-1:0]             index_q, index_d;
    logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
    logic [DATA_WIDTH-1:0]     out_q, out_d;

    logic          wr;
    logic          wr_ctrl;
    logic          wr_status;
    logic          wr_period;
    logic          wr_length;
    logic          wr_manual;
    logic          wr_pat;
    logic          pat_hit;
    logic [IW-1:0] pat_sel;
    logic          done_set;
    logic          unused_wdata;

    assign wr        = chipselect && !write_n;
    assign pat_hit   = address[3] && ({1'b0, address[2:0]} < DEPTH4);
    assign pat_sel   = address[IW-1:0];
    assign wr_ctrl   = wr && (address == 4'd0);
    assign wr_status = wr && (address == 4'd1);
    assign wr_period = wr && (address == 4'd2);
    assign wr_length = wr && (address == 4'd3);
    assign wr_manual = wr && (address == 4'd4);
    assign wr_pat    = wr && pat_hit;

    assign unused_wdata = &{1'b0, writedata};

    always_comb begin
        state_d   = state_q;
        ctrl_d    = ctrl_q;
        done_d    = done_q;
        period_d  = period_q;
        length_d  = length_q;
        manual_d  = manual_q;
        pattern_d = pattern_q;
        index_d   = index_q;
        presc_d   = presc_q;
        out_d     = out_q;
        done_set  = 1'b0;

        if (wr_ctrl)   ctrl_d   = writedata[2:0];
        if (wr_period) period_d = writedata[PRESCALE_WIDTH-1:0];
        if (wr_length) length_d = writedata[IW-1:0];
        if (wr_manual) manual_d = writedata[DATA_WIDTH-1:0];
        if (wr_pat)    pattern_d[pat_sel] = writedata[DATA_WIDTH-1:0];

        unique case (state_q)
            IDLE: out_d = manual_q;
            RUN: begin
                out_d = pattern_q[index_q];
                if (presc_q == '0) begin
                    presc_d = period_q;
                    if (index_q != length_q) begin
                        index_d = index_q + 1'b1;
                    end else if (ctrl_q[1]) begin
                        state_d  = DONE;
                        done_set = 1'b1;
                    end else begin
                        index_d = '0;
                    end
                end else begin
                    presc_d = presc_q - 1'b1;
                end
            end
            DONE: out_d = out_q;
            default: state_d = IDLE;
        endcase

        // a CTRL write always wins over the sequencer's own step
        if (wr_ctrl) begin
            if (writedata[0]) begin
                state_d = RUN;
                index_d = '0;
                presc_d = period_q;
            end else begin
                state_d = IDLE;
            end
        end

        if (wr_status && writedata[1]) done_d = 1'b0;
        if (done_set)                  done_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            ctrl_q   <= '0;
            done_q   <= 1'b0;
            period_q <= '0;
            length_q <= '0;
            manual_q <= '0;
            index_q  <= '0;
            presc_q  <= '0;
            out_q    <= '0;
            for (int i = 0; i < DEPTH; i++) pattern_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            done_q    <= done_d;
            period_q  <= period_d;
            length_q  <= length_d;
            manual_q  <= manual_d;
            pattern_q <= pattern_d;
            index_q   <= index_d;
            presc_q   <= presc_d;
            out_q     <= out_d;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            4'd0: readdata[2:0] = ctrl_q;
            4'd1: begin
                readdata[0]       = (state_q == RUN);
                readdata[1]       = done_q;
                readdata[4 +: IW] = index_q;
            end
            4'd2: readdata[PRESCALE_WIDTH-1:0] = period_q;
            4'd3: readdata[IW-1:0] = length_q;
            4'd4: readdata[DATA_WIDTH-1:0] = manual_q;
            default: begin
                if (pat_hit) readdata[DATA_WIDTH-1:0] = pattern_q[pat_sel];
            end
        endcase
    end

    assign out_port = out_q;
    assign irq      = done_q & ctrl_q[2];

endmodule
